// File: rtl/cardinal_dmem_responder_if.sv
// Bus bundle for the cardinal Dmem responder: core load/store port plus host FILL/DUMP streams.
// The master side (core + host loader) drives requests; the slave side is the responder.
interface cardinal_dmem_responder_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 64,
    parameter int LEN_W  = 9
);
    logic [ADDR_W-1:0] Proc_Addr;
    logic [0:DATA_W-1] Proc_WrData;
    logic              Proc_En;
    logic              Proc_WrEn;
    logic [0:DATA_W-1] Proc_RdData;
    logic              Proc_Conflict;

    logic [1:0]        Host_Cmd;
    logic              Host_Start;
    logic [ADDR_W-1:0] Host_Base;
    logic [LEN_W-1:0]  Host_Len;
    logic              Host_In_Valid;
    logic [0:DATA_W-1] Host_In_Data;
    logic              Host_In_Ready;
    logic              Host_Out_Valid;
    logic [0:DATA_W-1] Host_Out_Data;
    logic              Host_Out_Ready;
    logic              Host_Busy;
    logic              Host_Done;

    modport master (
        output Proc_Addr, Proc_WrData, Proc_En, Proc_WrEn,
        input  Proc_RdData, Proc_Conflict,
        output Host_Cmd, Host_Start, Host_Base, Host_Len,
        output Host_In_Valid, Host_In_Data, Host_Out_Ready,
        input  Host_In_Ready, Host_Out_Valid, Host_Out_Data, Host_Busy, Host_Done
    );

    modport slave (
        input  Proc_Addr, Proc_WrData, Proc_En, Proc_WrEn,
        output Proc_RdData, Proc_Conflict,
        input  Host_Cmd, Host_Start, Host_Base, Host_Len,
        input  Host_In_Valid, Host_In_Data, Host_Out_Ready,
        output Host_In_Ready, Host_Out_Valid, Host_Out_Data, Host_Busy, Host_Done
    );
endinterface

// File: rtl/cardinal_dmem_responder.sv
// Cardinal pipeline data memory: 256 x 64 store with a 1-cycle registered core read,
// plus a host FILL/DUMP engine that owns the array while busy (core accesses are dropped).
module cardinal_dmem_responder #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 64,
    parameter int LEN_W  = 9
) (
    input  logic                    Clock,
    input  logic                    Reset,
    cardinal_dmem_responder_if.slave bus
);
    localparam int DEPTH = 2 ** ADDR_W;

    typedef enum logic [2:0] {S_IDLE, S_FILL, S_DRD, S_DOUT, S_DONE} state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic [LEN_W-1:0]  cnt_q, cnt_d;
    logic [0:DATA_W-1] out_data_q, out_data_d;
    logic [0:DATA_W-1] rd_data_q, rd_data_d;
    logic              conflict_q, conflict_d;
    logic [0:DATA_W-1] mem_q [DEPTH];

    logic              busy;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [0:DATA_W-1] mem_wdata;

    assign busy = (state_q != S_IDLE);

    // NOTE: every variable driven here gets a default first, so no path leaves it unassigned (no latch).
    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        cnt_d      = cnt_q;
        out_data_d = out_data_q;
        rd_data_d  = rd_data_q;
        conflict_d = conflict_q;
        mem_we     = 1'b0;
        mem_waddr  = bus.Proc_Addr;
        mem_wdata  = bus.Proc_WrData;

        // Core port is only served while the host engine is idle.
        if (bus.Proc_En) begin
            if (busy) begin
                conflict_d = 1'b1;
            end else if (bus.Proc_WrEn) begin
                mem_we = 1'b1;
            end else begin
                rd_data_d = mem_q[bus.Proc_Addr];
            end
        end

        unique case (state_q)
            S_IDLE: begin
                if (bus.Host_Start && (bus.Host_Cmd == 2'b01 || bus.Host_Cmd == 2'b10)) begin
                    ptr_d = bus.Host_Base;
                    cnt_d = bus.Host_Len;
                    if (bus.Host_Len == '0) state_d = S_DONE;
                    else if (bus.Host_Cmd == 2'b01) state_d = S_FILL;
                    else state_d = S_DRD;
                end
            end
            S_FILL: begin
                if (bus.Host_In_Valid) begin
                    mem_we    = 1'b1;
                    mem_waddr = ptr_q;
                    mem_wdata = bus.Host_In_Data;
                    ptr_d     = ptr_q + ADDR_W'(1);
                    cnt_d     = cnt_q - LEN_W'(1);
                    if (cnt_q == LEN_W'(1)) state_d = S_DONE;
                end
            end
            S_DRD: begin
                out_data_d = mem_q[ptr_q];
                state_d    = S_DOUT;
            end
            S_DOUT: begin
                if (bus.Host_Out_Ready) begin
                    ptr_d   = ptr_q + ADDR_W'(1);
                    cnt_d   = cnt_q - LEN_W'(1);
                    state_d = (cnt_q == LEN_W'(1)) ? S_DONE : S_DRD;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q    <= S_IDLE;
            ptr_q      <= '0;
            cnt_q      <= '0;
            out_data_q <= '0;
            rd_data_q  <= '0;
            conflict_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            cnt_q      <= cnt_d;
            out_data_q <= out_data_d;
            rd_data_q  <= rd_data_d;
            conflict_q <= conflict_d;
        end
    end

    // NOTE: the array has no reset; contents survive Reset so a preload is not lost.
    always_ff @(posedge Clock) begin
        if (mem_we && !Reset) mem_q[mem_waddr] <= mem_wdata;
    end

    assign bus.Proc_RdData    = rd_data_q;
    assign bus.Proc_Conflict  = conflict_q;
    assign bus.Host_In_Ready  = (state_q == S_FILL);
    assign bus.Host_Out_Valid = (state_q == S_DOUT);
    assign bus.Host_Out_Data  = out_data_q;
    assign bus.Host_Busy      = busy;
    assign bus.Host_Done      = (state_q == S_DONE);
endmodule

// File: tb/tb_cardinal_dmem_responder.sv
// Directed bench for cardinal_dmem_responder: core load/store, host FILL/DUMP with wrap and stalls,
// busy conflicts, zero-length / invalid commands, and reset in the middle of a transfer.
module tb_cardinal_dmem_responder;
    logic Clock = 1'b0;
    logic Reset = 1'b1;
    int   n_cmp = 0;
    int   n_mis = 0;
    int   done_cnt = 0;

    localparam logic [63:0] D10   = 64'h0123_4567_89AB_CDEF;
    localparam logic [63:0] PRE20 = 64'h2020_2020_5A5A_5A5A;
    localparam logic [63:0] JUNK  = 64'hDEAD_BEEF_DEAD_BEEF;
    localparam logic [63:0] WA    = 64'hA5A5_0000_1111_0001;
    localparam logic [63:0] WB    = 64'hB6B6_2222_3333_0002;
    localparam logic [63:0] WC    = 64'hC7C7_4444_5555_0003;
    localparam logic [63:0] W0    = 64'h4040_0000_0000_00F0;
    localparam logic [63:0] W1    = 64'h4141_0000_0000_00F1;

    cardinal_dmem_responder_if #(.ADDR_W(8), .DATA_W(64), .LEN_W(9)) bus ();

    cardinal_dmem_responder #(.ADDR_W(8), .DATA_W(64), .LEN_W(9)) dut (
        .Clock (Clock),
        .Reset (Reset),
        .bus   (bus.slave)
    );

    always #5 Clock = ~Clock;

    always @(negedge Clock) if (bus.Host_Done === 1'b1) done_cnt++;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge Clock);
        #1;
    endtask

    task automatic load(input logic [7:0] addr);
        bus.Proc_En   = 1'b1;
        bus.Proc_WrEn = 1'b0;
        bus.Proc_Addr = addr;
        step();
        bus.Proc_En   = 1'b0;
    endtask

    initial begin
        bus.Proc_Addr = '0; bus.Proc_WrData = '0; bus.Proc_En = 1'b0; bus.Proc_WrEn = 1'b0;
        bus.Host_Cmd = 2'b00; bus.Host_Start = 1'b0; bus.Host_Base = '0; bus.Host_Len = '0;
        bus.Host_In_Valid = 1'b0; bus.Host_In_Data = '0; bus.Host_Out_Ready = 1'b0;

        step(); step();
        Reset = 1'b0;
        check("rst_rddata",   bus.Proc_RdData, 64'h0);
        check("rst_outdata",  bus.Host_Out_Data, 64'h0);
        check("rst_busy",     64'(bus.Host_Busy), 64'h0);
        check("rst_done",     64'(bus.Host_Done), 64'h0);
        check("rst_conflict", 64'(bus.Proc_Conflict), 64'h0);
        check("rst_outvalid", 64'(bus.Host_Out_Valid), 64'h0);
        check("rst_inready",  64'(bus.Host_In_Ready), 64'h0);

        // Core store then load, result one cycle after the load
        bus.Proc_En = 1'b1; bus.Proc_WrEn = 1'b1; bus.Proc_Addr = 8'h10; bus.Proc_WrData = D10;
        step();
        bus.Proc_WrEn = 1'b0;
        step();
        check("core_load_10", bus.Proc_RdData, D10);
        bus.Proc_En = 1'b0;
        step();
        check("core_rd_hold", bus.Proc_RdData, D10);
        bus.Proc_En = 1'b1; bus.Proc_WrEn = 1'b1; bus.Proc_Addr = 8'h20; bus.Proc_WrData = PRE20;
        step();
        bus.Proc_En = 1'b0; bus.Proc_WrEn = 1'b0;

        // FILL FE..00 with toggling valid; core store to 0x20 lands while busy
        bus.Host_Cmd = 2'b01; bus.Host_Base = 8'hFE; bus.Host_Len = 9'd3; bus.Host_Start = 1'b1;
        step();
        bus.Host_Start = 1'b0; bus.Host_Cmd = 2'b00;
        check("fill_busy",    64'(bus.Host_Busy), 64'h1);
        check("fill_inready", 64'(bus.Host_In_Ready), 64'h1);
        bus.Proc_En = 1'b1; bus.Proc_WrEn = 1'b1; bus.Proc_Addr = 8'h20; bus.Proc_WrData = JUNK;
        step();
        bus.Proc_En = 1'b0; bus.Proc_WrEn = 1'b0;
        check("conflict_set", 64'(bus.Proc_Conflict), 64'h1);
        bus.Host_In_Valid = 1'b1; bus.Host_In_Data = WA; step();
        bus.Host_In_Valid = 1'b0; step();
        bus.Host_In_Valid = 1'b1; bus.Host_In_Data = WB; step();
        bus.Host_In_Valid = 1'b0; step();
        bus.Host_In_Valid = 1'b1; bus.Host_In_Data = WC; step();
        bus.Host_In_Valid = 1'b0;
        check("fill_done",      64'(bus.Host_Done), 64'h1);
        check("fill_done_busy", 64'(bus.Host_Busy), 64'h1);
        check("fill_done_rdy",  64'(bus.Host_In_Ready), 64'h0);
        step();
        check("fill_done_end",  64'(bus.Host_Done), 64'h0);
        check("fill_idle",      64'(bus.Host_Busy), 64'h0);
        check("fill_done_cnt",  64'(done_cnt), 64'd1);
        load(8'hFE); check("mem_FE", bus.Proc_RdData, WA);
        load(8'hFF); check("mem_FF", bus.Proc_RdData, WB);
        load(8'h00); check("mem_00", bus.Proc_RdData, WC);
        load(8'h20); check("mem_20_kept", bus.Proc_RdData, PRE20);
        check("conflict_sticky", 64'(bus.Proc_Conflict), 64'h1);

        // DUMP FE..00 with a 4-cycle stall on the second word
        bus.Host_Cmd = 2'b10; bus.Host_Base = 8'hFE; bus.Host_Len = 9'd3; bus.Host_Start = 1'b1;
        bus.Host_Out_Ready = 1'b1;
        step();
        bus.Host_Start = 1'b0; bus.Host_Cmd = 2'b00;
        check("dump_drd_valid", 64'(bus.Host_Out_Valid), 64'h0);
        step();
        check("dump_a_valid", 64'(bus.Host_Out_Valid), 64'h1);
        check("dump_a_data",  bus.Host_Out_Data, WA);
        step();
        check("dump_gap_valid", 64'(bus.Host_Out_Valid), 64'h0);
        bus.Host_Out_Ready = 1'b0;
        step();
        check("dump_b_valid", 64'(bus.Host_Out_Valid), 64'h1);
        check("dump_b_data",  bus.Host_Out_Data, WB);
        for (int i = 0; i < 4; i++) begin
            step();
            check("dump_stall_valid", 64'(bus.Host_Out_Valid), 64'h1);
            check("dump_stall_data",  bus.Host_Out_Data, WB);
        end
        bus.Host_Out_Ready = 1'b1;
        step();
        step();
        check("dump_c_valid", 64'(bus.Host_Out_Valid), 64'h1);
        check("dump_c_data",  bus.Host_Out_Data, WC);
        step();
        check("dump_done",       64'(bus.Host_Done), 64'h1);
        check("dump_done_valid", 64'(bus.Host_Out_Valid), 64'h0);
        step();
        bus.Host_Out_Ready = 1'b0;
        check("dump_idle",     64'(bus.Host_Busy), 64'h0);
        check("dump_done_cnt", 64'(done_cnt), 64'd2);

        // Zero-length DUMP finishes at once; Cmd=11 is ignored
        bus.Host_Cmd = 2'b10; bus.Host_Base = 8'h30; bus.Host_Len = 9'd0; bus.Host_Start = 1'b1;
        step();
        bus.Host_Start = 1'b0;
        check("len0_done",  64'(bus.Host_Done), 64'h1);
        check("len0_valid", 64'(bus.Host_Out_Valid), 64'h0);
        step();
        check("len0_idle",  64'(bus.Host_Busy), 64'h0);
        check("len0_no_rd", bus.Host_Out_Data, WC);
        bus.Host_Cmd = 2'b11; bus.Host_Len = 9'd5; bus.Host_Start = 1'b1;
        step();
        bus.Host_Start = 1'b0; bus.Host_Cmd = 2'b00;
        check("cmd11_idle", 64'(bus.Host_Busy), 64'h0);
        step();
        check("cmd11_no_done", 64'(bus.Host_Done), 64'h0);
        check("len0_done_cnt", 64'(done_cnt), 64'd3);

        // Reset in the middle of an 8-word FILL
        bus.Host_Cmd = 2'b01; bus.Host_Base = 8'h40; bus.Host_Len = 9'd8; bus.Host_Start = 1'b1;
        step();
        bus.Host_Start = 1'b0; bus.Host_Cmd = 2'b00;
        bus.Host_In_Valid = 1'b1; bus.Host_In_Data = W0; step();
        bus.Host_In_Data = W1; step();
        bus.Host_In_Valid = 1'b0;
        bus.Host_Cmd = 2'b10; bus.Host_Base = 8'h00; bus.Host_Len = 9'd1; bus.Host_Start = 1'b1;
        bus.Proc_En = 1'b1; bus.Proc_WrEn = 1'b0; bus.Proc_Addr = 8'h10;
        step();
        bus.Host_Start = 1'b0; bus.Host_Cmd = 2'b00; bus.Proc_En = 1'b0;
        check("busy_start_ignored", 64'(bus.Host_In_Ready), 64'h1);
        check("busy_still",         64'(bus.Host_Busy), 64'h1);
        check("busy_load_dropped",  bus.Proc_RdData, PRE20);
        Reset = 1'b1;
        step();
        Reset = 1'b0;
        check("midrst_idle",     64'(bus.Host_Busy), 64'h0);
        check("midrst_conflict", 64'(bus.Proc_Conflict), 64'h0);
        check("midrst_inready",  64'(bus.Host_In_Ready), 64'h0);
        check("midrst_no_done",  64'(bus.Host_Done), 64'h0);
        step();
        check("midrst_done_cnt", 64'(done_cnt), 64'd3);
        load(8'h40); check("mem_40", bus.Proc_RdData, W0);
        load(8'h41); check("mem_41", bus.Proc_RdData, W1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end
endmodule
